// File: rtl/keccak_pkg.sv
// Shared Keccak constants, loader state encoding and lane index helper.
// The lane index maps to a 5x5 grid, x varies fastest.
package keccak_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int GRID      = 5;

  typedef enum logic [1:0] {INIT, ABSORB, PERM, DONE} absorb_state_t;

  function automatic logic [5:0] lane_xy(input logic [4:0] index);
    logic [2:0] x;
    logic [2:0] y;
    x = 3'(index % 5'(GRID));
    y = 3'(index / 5'(GRID));
    return {x, y};
  endfunction

endpackage

// File: rtl/absorb_ld_if.sv
// Lane stream plus state-memory port bundle between the loader and its environment.
// slave = loader side, master = upstream source / memory side.
interface absorb_ld_if;
  import keccak_pkg::*;

  logic [LANE_W-1:0] din;
  logic              din_valid;
  logic              din_last;
  logic              din_ready;
  logic [2:0]        m_rx;
  logic [2:0]        m_ry;
  logic [LANE_W-1:0] m_rd;
  logic [2:0]        m_wx;
  logic [2:0]        m_wy;
  logic              m_wr;
  logic [LANE_W-1:0] m_wd;

  modport master (
    output din, din_valid, din_last, m_rd,
    input  din_ready, m_rx, m_ry, m_wx, m_wy, m_wr, m_wd
  );

  modport slave (
    input  din, din_valid, din_last, m_rd,
    output din_ready, m_rx, m_ry, m_wx, m_wy, m_wr, m_wd
  );

endinterface

// File: rtl/absorb_ld_lane_xy_ctr.sv
// Mod-5 x / mod-5 y lane counter; term flags the lane numbered count-1.
// Zero latency on term (combinational from the counter); clr beats inc.
module lane_xy_ctr
  import keccak_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic [4:0] count,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       term
);

  assign term = ({x, y} == lane_xy(count - 5'd1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x <= 3'd0;
      y <= 3'd0;
    end else if (inc) begin
      if (x == 3'(GRID - 1)) begin
        x <= 3'd0;
        y <= y + 3'd1;
      end else begin
        x <= x + 3'd1;
      end
    end
  end

endmodule

// File: rtl/absorb_ld.sv
// Keccak absorb loader: zeroes the state, XORs RATE_LANES lanes in, then hands the memory to perm_blk.
// Last accepted lane -> perm_start in 1 cycle; din_ready is low outside ABSORB.
module absorb_ld
  import keccak_pkg::*;
#(
  parameter int RATE_LANES = 17
) (
  input  logic clk,
  input  logic rst,
  absorb_ld_if.slave bus,
  output logic mem_own,
  output logic perm_start,
  input  logic perm_done,
  output logic msg_done,
  output logic busy
);

  localparam logic [4:0] RATE_CNT = 5'(RATE_LANES);
  localparam logic [4:0] INIT_CNT = 5'(NUM_LANES);

  absorb_state_t state;
  logic          last_flag;
  logic          rdy_q;
  logic [2:0]    cx;
  logic [2:0]    cy;
  logic          term;
  logic          accept;
  logic          inc;
  logic [4:0]    cnt_lim;

  assign accept  = (state == ABSORB) && bus.din_valid;
  assign inc     = (state == INIT) || accept;
  assign cnt_lim = (state == INIT) ? INIT_CNT : RATE_CNT;

  lane_xy_ctr u_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clr   (inc && term),
    .count (cnt_lim),
    .x     (cx),
    .y     (cy),
    .term  (term)
  );

  assign bus.din_ready = rdy_q;
  assign bus.m_rx      = cx;
  assign bus.m_ry      = cy;
  assign bus.m_wx      = cx;
  assign bus.m_wy      = cy;
  // Writes are suppressed while rst is held so a mid-flight reset never touches memory.
  assign bus.m_wr      = !rst && inc;
  assign bus.m_wd      = (state == ABSORB) ? (bus.m_rd ^ bus.din) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      last_flag  <= 1'b0;
      rdy_q      <= 1'b0;
      mem_own    <= 1'b1;
      busy       <= 1'b1;
      perm_start <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      perm_start <= 1'b0;
      msg_done   <= 1'b0;
      case (state)
        INIT: begin
          if (term) begin
            state <= ABSORB;
            rdy_q <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ABSORB: begin
          if (accept && term) begin
            state      <= PERM;
            last_flag  <= bus.din_last;
            rdy_q      <= 1'b0;
            busy       <= 1'b1;
            mem_own    <= 1'b0;
            perm_start <= 1'b1;
          end
        end
        PERM: begin
          // perm_start is high only in the first PERM cycle, where perm_done is not honoured.
          if (perm_done && !perm_start) begin
            mem_own <= 1'b1;
            if (last_flag) begin
              state    <= DONE;
              msg_done <= 1'b1;
            end else begin
              state <= ABSORB;
              rdy_q <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          last_flag <= 1'b0;
          state     <= INIT;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_absorb_ld.sv
// Bench for absorb_ld: memory models, a stand-in for perm_blk, table vectors and random messages.
module tb_absorb_ld;

  typedef struct packed {
    logic        valid;
    logic [63:0] din;
    logic        exp_wr;
    logic [2:0]  exp_x;
    logic [2:0]  exp_y;
    logic [63:0] exp_wd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  absorb_ld_if b17 ();
  absorb_ld_if b25 ();
  logic own17, ps17, pd17, md17, busy17;
  logic own25, ps25, pd25, md25, busy25;

  absorb_ld #(.RATE_LANES(17)) u17 (
    .clk(clk), .rst(rst), .bus(b17), .mem_own(own17), .perm_start(ps17),
    .perm_done(pd17), .msg_done(md17), .busy(busy17)
  );
  absorb_ld #(.RATE_LANES(25)) u25 (
    .clk(clk), .rst(rst), .bus(b25), .mem_own(own25), .perm_start(ps25),
    .perm_done(pd25), .msg_done(md25), .busy(busy25)
  );

  logic [63:0] mem17 [25];
  logic [63:0] mem25 [25];
  logic [63:0] exp17 [25];
  logic [63:0] exp25 [25];
  logic        perm_fill_en;
  logic [63:0] perm_fill;
  int          ps_cnt17 = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // Stand-in for the permutation: any fixed per-lane transform of the state will do.
  function automatic logic [63:0] scramble(input logic [63:0] v, input int i);
    return {v[62:0], v[63]} ^ (64'(i + 1) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  assign b17.m_rd = mem17[int'(b17.m_ry) * 5 + int'(b17.m_rx)];
  assign b25.m_rd = mem25[int'(b25.m_ry) * 5 + int'(b25.m_rx)];

  always @(posedge clk) begin
    if (b17.m_wr && own17) mem17[int'(b17.m_wy) * 5 + int'(b17.m_wx)] <= b17.m_wd;
    if (pd17 && !own17)
      for (int i = 0; i < 25; i++) mem17[i] <= perm_fill_en ? perm_fill : scramble(mem17[i], i);
    if (b25.m_wr && own25) mem25[int'(b25.m_wy) * 5 + int'(b25.m_wx)] <= b25.m_wd;
    if (ps17) ps_cnt17 <= ps_cnt17 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem17(input string name);
    for (int i = 0; i < 25; i++) chk(name, mem17[i], exp17[i]);
  endtask

  // Starts in the first INIT cycle, ends one cycle into ABSORB.
  task automatic check_init17();
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk("init_wr", 64'(b17.m_wr), 64'd1);
      chk("init_wd", b17.m_wd, 64'd0);
      chk("init_xy", 64'({b17.m_wx, b17.m_wy}), 64'({3'(k % 5), 3'(k / 5)}));
      chk("init_rdy", 64'(b17.din_ready), 64'd0);
      chk("init_own", 64'(own17), 64'd1);
      chk("init_md", 64'(md17), 64'd0);
      nxt();
    end
    @(negedge clk);
    chk("init_end_rdy", 64'(b17.din_ready), 64'd1);
    chk("init_end_busy", 64'(busy17), 64'd0);
    for (int i = 0; i < 25; i++) exp17[i] = '0;
    nxt();
  endtask

  task automatic send17(input logic [63:0] d, input logic last, input int k);
    b17.din = d;
    b17.din_valid = 1'b1;
    b17.din_last = last;
    @(negedge clk);
    chk("abs_wr", 64'(b17.m_wr), 64'd1);
    chk("abs_xy", 64'({b17.m_wx, b17.m_wy}), 64'({3'(k % 5), 3'(k / 5)}));
    chk("abs_wd", b17.m_wd, exp17[k] ^ d);
    chk("abs_ps", 64'(ps17), 64'd0);
    exp17[k] ^= d;
    nxt();
    b17.din_valid = 1'b0;
    b17.din_last = 1'b0;
  endtask

  task automatic idle17(input int k, input logic stray);
    b17.din_valid = 1'b0;
    b17.din = {$urandom, $urandom};
    pd17 = stray;
    @(negedge clk);
    chk("idle_wr", 64'(b17.m_wr), 64'd0);
    chk("idle_xy", 64'({b17.m_wx, b17.m_wy}), 64'({3'(k % 5), 3'(k / 5)}));
    chk("idle_rdy", 64'(b17.din_ready), 64'd1);
    nxt();
    pd17 = 1'b0;
  endtask

  // Starts in the first PERM cycle; ends in the cycle after the one following perm_done.
  task automatic perm17(input int delay, input logic last, input logic fill, input logic [63:0] fv);
    int ps0;
    @(negedge clk);
    ps0 = ps_cnt17;
    chk("perm_start", 64'(ps17), 64'd1);
    chk("perm_own", 64'(own17), 64'd0);
    chk("perm_rdy", 64'(b17.din_ready), 64'd0);
    chk("perm_busy", 64'(busy17), 64'd1);
    nxt();
    for (int c = 0; c < delay; c++) begin
      @(negedge clk);
      chk("perm_hold_ps", 64'(ps17), 64'd0);
      chk("perm_hold_own", 64'(own17), 64'd0);
      chk("perm_hold_wr", 64'(b17.m_wr), 64'd0);
      nxt();
    end
    perm_fill_en = fill;
    perm_fill = fv;
    pd17 = 1'b1;
    nxt();
    pd17 = 1'b0;
    for (int i = 0; i < 25; i++) exp17[i] = fill ? fv : scramble(exp17[i], i);
    @(negedge clk);
    chk("perm_pulses", 64'(ps_cnt17), 64'(ps0 + 1));
    chk("post_own", 64'(own17), 64'd1);
    chk("post_md", 64'(md17), 64'(last));
    chk("post_rdy", 64'(b17.din_ready), 64'(!last));
    chk("post_busy", 64'(busy17), 64'(last));
    check_mem17("perm_mem");
    nxt();
  endtask

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    int          acc;
    int          nb;
    int          psb;
    logic [63:0] d;

    for (int b = 0; b < 17; b++) begin
      v.valid = 1'b1; v.din = 64'h0F0F_0F0F_0F0F_0F0F; v.exp_wr = 1'b1;
      v.exp_x = 3'(b % 5); v.exp_y = 3'(b / 5); v.exp_wd = 64'hF0F0_F0F0_F0F0_F0F0;
      tbl.push_back(v);
      if (b < 16) begin
        repeat (2) begin
          v.valid = 1'b0; v.exp_wr = 1'b0;
          v.exp_x = 3'((b + 1) % 5); v.exp_y = 3'((b + 1) / 5);
          tbl.push_back(v);
        end
      end
    end
    for (int i = 0; i < 25; i++) begin
      exp17[i] = '0;
      exp25[i] = '0;
    end

    rst = 1'b1; pd17 = 1'b0; pd25 = 1'b0; perm_fill_en = 1'b0; perm_fill = '0;
    b17.din = '0; b17.din_valid = 1'b0; b17.din_last = 1'b0;
    b25.din = '0; b25.din_valid = 1'b0; b25.din_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rdy", 64'(b17.din_ready), 64'd0);
    chk("rst_wr", 64'(b17.m_wr), 64'd0);
    chk("rst_ps", 64'(ps17), 64'd0);
    chk("rst_md", 64'(md17), 64'd0);
    chk("rst_own", 64'(own17), 64'd1);
    chk("rst_busy", 64'(busy17), 64'd1);
    nxt();
    rst = 1'b0;

    check_init17();
    check_mem17("t1_zero");

    for (int i = 0; i < 17; i++) send17(64'(i + 1), 1'b0, i);
    check_mem17("t2_mem");
    perm17(5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

    acc = 0;
    foreach (tbl[j]) begin
      b17.din = tbl[j].din;
      b17.din_valid = tbl[j].valid;
      b17.din_last = 1'b0;
      @(negedge clk);
      chk("tbl_wr", 64'(b17.m_wr), 64'(tbl[j].exp_wr));
      chk("tbl_xy", 64'({b17.m_wx, b17.m_wy}), 64'({tbl[j].exp_x, tbl[j].exp_y}));
      if (tbl[j].valid) begin
        chk("tbl_wd", b17.m_wd, tbl[j].exp_wd);
        exp17[acc] ^= tbl[j].din;
        acc++;
      end
      nxt();
    end
    b17.din_valid = 1'b0;
    check_mem17("t3_mem");
    perm17(3, 1'b0, 1'b0, '0);

    for (int m = 0; m < 2; m++) begin
      nb = $urandom_range(1, 2);
      for (int blk = 0; blk < nb; blk++) begin
        for (int k = 0; k < 17; k++) begin
          repeat ($urandom_range(0, 2)) idle17(k, 1'($urandom_range(0, 3) == 0));
          d = {$urandom, $urandom};
          send17(d, (k == 16) ? 1'(blk == nb - 1) : 1'($urandom % 2), k);
        end
        perm17((blk == nb - 1) ? 30 : $urandom_range(1, 8), 1'(blk == nb - 1), 1'b0, '0);
      end
      check_init17();
      check_mem17("t5_zero");
    end

    psb = ps_cnt17;
    for (int k = 0; k < 9; k++) send17({$urandom, $urandom}, 1'b0, k);
    rst = 1'b1;
    b17.din_valid = 1'b1;
    b17.din = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    chk("t6_rst_wr", 64'(b17.m_wr), 64'd0);
    nxt();
    rst = 1'b0;
    b17.din_valid = 1'b0;
    check_init17();
    check_mem17("t6_zero");
    chk("t6_no_perm", 64'(ps_cnt17), 64'(psb));

    for (int k = 0; k < 25; k++) begin
      d = {$urandom, $urandom};
      b25.din = d;
      b25.din_valid = 1'b1;
      b25.din_last = 1'(k == 24);
      @(negedge clk);
      chk("r25_wr", 64'(b25.m_wr), 64'd1);
      chk("r25_xy", 64'({b25.m_wx, b25.m_wy}), 64'({3'(k % 5), 3'(k / 5)}));
      chk("r25_wd", b25.m_wd, exp25[k] ^ d);
      chk("r25_ps", 64'(ps25), 64'd0);
      chk("r25_busy", 64'(busy25), 64'd0);
      exp25[k] ^= d;
      nxt();
    end
    b25.din_valid = 1'b0;
    b25.din_last = 1'b0;
    @(negedge clk);
    chk("r25_perm_start", 64'(ps25), 64'd1);
    chk("r25_own", 64'(own25), 64'd0);
    for (int i = 0; i < 25; i++) chk("r25_mem", mem25[i], exp25[i]);
    nxt();
    nxt();
    pd25 = 1'b1;
    nxt();
    pd25 = 1'b0;
    @(negedge clk);
    chk("r25_msg_done", 64'(md25), 64'd1);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/absorb_ld.md
Name: absorb_ld

Overview:
- Upstream loader for the Keccak permutation block. Accepts 64-bit message lanes over a valid/ready stream and XOR-absorbs them into the 5x5x64 state memory through its read/write ports.
- After RATE_LANES lanes, hands memory ownership to perm_blk and waits for it to finish.
- Zeroes the state before each new message.

Parameters:
RATE_LANES, 17, lanes absorbed per block (legal 1..25; 17 = SHA3-256 rate of 1088 bits)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
din  in  64  message lane (already padded upstream)
din_valid  in  1  lane valid
din_last  in  1  final block of message; sampled only on the beat that completes a block
din_ready  out  1  loader accepts lane
m_rx  out  3  state memory read x
m_ry  out  3  state memory read y
m_rd  in  64  state memory read data (combinational from m_rx/m_ry)
m_wx  out  3  state memory write x
m_wy  out  3  state memory write y
m_wr  out  1  state memory write enable (memory writes on posedge clk)
m_wd  out  64  state memory write data
mem_own  out  1  1 = loader drives memory ports; 0 = perm_blk owns them (external mux select)
perm_start  out  1  one-cycle pulse to start permutation
perm_done  in  1  one-cycle pulse from perm_blk on completion
msg_done  out  1  one-cycle pulse: final permutation of message complete, state valid for squeeze
busy  out  1  high in every state except ABSORB

Behaviour:
- Lane index i in 0..24 maps to x = i mod 5, y = i / 5 (x fastest). The lane counter is kept as an (x, y) pair.
- m_rx/m_ry and m_wx/m_wy always equal the current lane counter.
- States: INIT, ABSORB, PERM, DONE.
- Reset (sync, rst=1 at posedge):
  - state=INIT, counter=(0,0), last_flag=0.
  - Outputs: din_ready=0, m_wr=0, perm_start=0, msg_done=0, mem_own=1, busy=1.
  - A reset mid-operation from any state behaves identically; a PERM in progress is abandoned and perm_done is ignored.
- INIT:
  - m_wr=1, m_wd=0 every cycle; counter steps 0..24; exactly 25 cycles.
  - At lane 24 the counter wraps to (0,0) and the state goes to ABSORB.
  - din_ready=0.
- ABSORB:
  - din_ready=1, mem_own=1, busy=0.
  - m_wr = din_valid (combinational); m_wd = m_rd XOR din.
  - On each accepted beat (valid & ready) the counter advances. Cycles with din_valid=0 do not write and do not advance.
  - When the beat at lane RATE_LANES-1 is accepted: latch last_flag=din_last, reset the counter to (0,0), and go to PERM.
  - din_last on any other beat is ignored.
- PERM:
  - perm_start=1 in the first PERM cycle only.
  - mem_own=0, m_wr=0, din_ready=0.
  - perm_done is honoured from the second PERM cycle onward. On perm_done: go to DONE if last_flag, else to ABSORB.
  - perm_done in any other state is ignored.
- DONE:
  - msg_done=1 for exactly one cycle, last_flag cleared, then INIT (state re-zeroed for the next message).
- Lanes RATE_LANES..24 are never written during ABSORB (capacity untouched).
- RATE_LANES=25: the block completes at lane (4,4); no out-of-range address is generated.
- Latency:
  - Last accepted lane to perm_start: 1 cycle.
  - perm_done to din_ready (non-last block): 1 cycle.
  - perm_done to msg_done: 1 cycle; then 25 INIT cycles before din_ready.

Decomposition:
- Shared package keccak_pkg:
  - LANE_W=64, NUM_LANES=25, GRID=5.
  - absorb_state_t enum {INIT, ABSORB, PERM, DONE}.
  - Function lane_xy(index) returning {x, y}.
- Sub-module lane_xy_ctr: mod-5 x / mod-5 y counter with inc, clear, and a terminal flag at a programmable lane count. It is reused by INIT (count 25) and ABSORB (count RATE_LANES).

Test Plan:
1. Release rst -> m_wr=1 with m_wd=0 for 25 consecutive cycles at (0,0),(1,0)..(4,4); din_ready rises the cycle after lane (4,4); the memory model reads all lanes 0.
2. Zeroed state, stream 17 lanes din=i+1 back-to-back, din_last=0 -> lane(i mod 5, i/5)=i+1; lanes 17..24 remain 0; perm_start pulses exactly once, 1 cycle after the 17th accept; mem_own=0 while perm_done is held off.
3. Memory model preloaded with lanes all 64'hFFFF_FFFF_FFFF_FFFF (after first perm_done), stream din=64'h0F0F_0F0F_0F0F_0F0F -> each rate lane reads 64'hF0F0_F0F0_F0F0_F0F0.
4. din_valid toggling 1,0,0,1,... over 17 beats -> writes only on valid cycles; addresses contiguous; perm_start timing relative to the last accept unchanged.
5. Block with din_last=1 on beat 17, perm_done delayed 30 cycles -> msg_done pulses 1 cycle after perm_done, followed by 25 zeroing writes; a stray perm_done pulse in ABSORB causes no state change.
6. rst asserted after 9 accepted lanes -> next cycle INIT with counter (0,0) and perm_start never pulses; repeat the whole flow with RATE_LANES=25 -> final write at (4,4), perm_start 1 cycle later.
